// File: rtl/vga_tile_grid.sv
// ---------------------------------------------------------------------------
// vga_tile_grid
// Generates 640x480@60 VGA timing and renders a GRID_COLS x GRID_ROWS board
// of tiles. Black grid lines separate the tiles. Each tile is filled through a
// 16-entry palette. A cursor frame, which can blink, can be drawn on one cell.
//
// Ports
//   VGA_CLK_IN   pixel clock
//   rst          asynchronous reset, active low
//   cell_codes   4-bit colour code per cell; cell k = row*GRID_COLS+col
//   cursor_idx   cursor cell index (values >= cell count draw no cursor)
//   cursor_en    cursor frame enable
//   blink_en     cursor frame blinks on frameCnt[BLINK_SHIFT] when set
//   o_hsync      horizontal sync, active low
//   o_vsync      vertical sync, active low
//   o_de         display enable
//   frame_tick   one-cycle pulse on the first cycle of vsync
//   VGA_CLK_OUT  pass-through of VGA_CLK_IN
//   out_R/G/B    8-bit pixel colour, 0 while blanked
//
// Optional feature macro: VGA_CROSS_TILE_EN
//   When defined, each tile draws a centred plus-shaped glyph in its palette
//   colour on a white background. When undefined, each tile is a solid fill.
//
// All outputs are registered. Their latency from the counter position is 2
// cycles. Geometry comes from running offset counters, so no dividers are used.
// ---------------------------------------------------------------------------
module vga_tile_grid #(
   parameter int H_VISIBLE   = 640,
   parameter int H_FRONT     = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BACK      = 48,
   parameter int V_VISIBLE   = 480,
   parameter int V_FRONT     = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter int GRID_COLS   = 4,
   parameter int GRID_ROWS   = 4,
   parameter int TILE_W      = 70,
   parameter int TILE_H      = 70,
   parameter int LINE_W      = 5,
   parameter int ORIGIN_X    = 160,
   parameter int ORIGIN_Y    = 120,
   parameter int CURSOR_W    = 4,
   parameter int BLINK_SHIFT = 5,
   localparam int CELLS      = GRID_COLS * GRID_ROWS,
   localparam int IDX_W      = (CELLS > 1) ? $clog2(CELLS) : 1
) (
   input  logic               VGA_CLK_IN,
   input  logic               rst,
   input  logic [4*CELLS-1:0] cell_codes,
   input  logic [IDX_W-1:0]   cursor_idx,
   input  logic               cursor_en,
   input  logic               blink_en,
   output logic               o_hsync,
   output logic               o_vsync,
   output logic               o_de,
   output logic               frame_tick,
   output logic               VGA_CLK_OUT,
   output logic [7:0]         out_R,
   output logic [7:0]         out_G,
   output logic [7:0]         out_B
);

   localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_START = H_VISIBLE + H_FRONT;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_VISIBLE + V_FRONT;
   localparam int VS_END   = VS_START + V_SYNC;
   localparam int PX       = TILE_W + LINE_W;
   localparam int PY       = TILE_H + LINE_W;
   localparam int HW       = $clog2(H_TOTAL);
   localparam int VW       = $clog2(V_TOTAL);
   localparam int XW       = $clog2(PX);
   localparam int YW       = $clog2(PY);
   localparam int CW       = $clog2(GRID_COLS + 1);
   localparam int RW       = $clog2(GRID_ROWS + 1);

   assign VGA_CLK_OUT = VGA_CLK_IN;

   function automatic logic [23:0] palette(input logic [3:0] c);
      case (c)
         4'd0:    palette = 24'hFFFFFF;
         4'd1:    palette = 24'hCCFF99;
         4'd2:    palette = 24'h0D1E86;
         4'd3:    palette = 24'h00FF00;
         4'd4:    palette = 24'hD10E49;
         4'd5:    palette = 24'h0000FF;
         4'd6:    palette = 24'hD1C50E;
         4'd7:    palette = 24'hF39C12;
         4'd8:    palette = 24'h7F8C8D;
         default: palette = 24'h404040;
      endcase
   endfunction

   // ---------------- raster counters ----------------
   logic [HW-1:0] hCnt, hNext;
   logic [VW-1:0] vCnt, vNext;
   logic          hWrap;

   always_comb begin
      hWrap = (hCnt == HW'(H_TOTAL - 1));
      hNext = hWrap ? '0 : hCnt + 1'b1;
      vNext = (vCnt == VW'(V_TOTAL - 1)) ? '0 : vCnt + 1'b1;
   end

   always_ff @(posedge VGA_CLK_IN or negedge rst) begin
      if (!rst) begin
         hCnt <= '0;
         vCnt <= '0;
      end else begin
         hCnt <= hNext;
         if (hWrap) vCnt <= vNext;
      end
   end

   // ---------------- grid trackers ----------------
   // xOff/col describe the current hCnt. They are primed from hNext so the
   // offset is 0 on the cycle where hCnt == ORIGIN_X. col reaches GRID_COLS
   // only for the closing line. After that line the tracker stops.
   logic          inX, inY;
   logic [XW-1:0] xOff;
   logic [YW-1:0] yOff;
   logic [CW-1:0] col;
   logic [RW-1:0] row;

   always_ff @(posedge VGA_CLK_IN or negedge rst) begin
      if (!rst) begin
         inX  <= (ORIGIN_X == 0);
         xOff <= '0;
         col  <= '0;
      end else if (hNext == HW'(ORIGIN_X)) begin
         inX  <= 1'b1;
         xOff <= '0;
         col  <= '0;
      end else if (inX) begin
         if (col == CW'(GRID_COLS) && xOff == XW'(LINE_W - 1)) begin
            inX <= 1'b0;
         end else if (xOff == XW'(PX - 1)) begin
            xOff <= '0;
            col  <= col + 1'b1;
         end else begin
            xOff <= xOff + 1'b1;
         end
      end
   end

   always_ff @(posedge VGA_CLK_IN or negedge rst) begin
      if (!rst) begin
         inY  <= (ORIGIN_Y == 0);
         yOff <= '0;
         row  <= '0;
      end else if (hWrap) begin
         if (vNext == VW'(ORIGIN_Y)) begin
            inY  <= 1'b1;
            yOff <= '0;
            row  <= '0;
         end else if (inY) begin
            if (row == RW'(GRID_ROWS) && yOff == YW'(LINE_W - 1)) begin
               inY <= 1'b0;
            end else if (yOff == YW'(PY - 1)) begin
               yOff <= '0;
               row  <= row + 1'b1;
            end else begin
               yOff <= yOff + 1'b1;
            end
         end
      end
   end

   // ---------------- stage 1 ----------------
   logic          s1De, s1Hs, s1Vs, s1Tick, s1Grid, s1Line;
   logic [CW-1:0] s1Col;
   logic [RW-1:0] s1Row;
   logic [XW-1:0] s1TileX;
   logic [YW-1:0] s1TileY;

   always_ff @(posedge VGA_CLK_IN or negedge rst) begin
      if (!rst) begin
         s1De    <= 1'b0;
         s1Hs    <= 1'b1;
         s1Vs    <= 1'b1;
         s1Tick  <= 1'b0;
         s1Grid  <= 1'b0;
         s1Line  <= 1'b0;
         s1Col   <= '0;
         s1Row   <= '0;
         s1TileX <= '0;
         s1TileY <= '0;
      end else begin
         s1De    <= (hCnt < HW'(H_VISIBLE)) && (vCnt < VW'(V_VISIBLE));
         s1Hs    <= !((hCnt >= HW'(HS_START)) && (hCnt < HW'(HS_END)));
         s1Vs    <= !((vCnt >= VW'(VS_START)) && (vCnt < VW'(VS_END)));
         s1Tick  <= (hCnt == '0) && (vCnt == VW'(VS_START));
         s1Grid  <= inX && inY;
         s1Line  <= (xOff < XW'(LINE_W)) || (yOff < YW'(LINE_W));
         s1Col   <= col;
         s1Row   <= row;
         // Wraps to a large value on line pixels. s1Line masks those pixels.
         s1TileX <= xOff - XW'(LINE_W);
         s1TileY <= yOff - YW'(LINE_W);
      end
   end

   // ---------------- per-frame shadow ----------------
   logic [4*CELLS-1:0] codesS;
   logic [IDX_W-1:0]   cursorS;
   logic               cursorEnS, blinkEnS;
   logic [7:0]         frameCnt;

   always_ff @(posedge VGA_CLK_IN or negedge rst) begin
      if (!rst) begin
         codesS    <= '0;
         cursorS   <= '0;
         cursorEnS <= 1'b0;
         blinkEnS  <= 1'b0;
         frameCnt  <= '0;
      end else if (frame_tick) begin
         codesS    <= cell_codes;
         cursorS   <= cursor_idx;
         cursorEnS <= cursor_en;
         blinkEnS  <= blink_en;
         frameCnt  <= frameCnt + 1'b1;
      end
   end

   // ---------------- stage 2 ----------------
   logic [7:0]  cellIdx;
   logic [3:0]  code;
   logic        onEdge, cursorHere;
   logic [23:0] tileRgb, pixRgb;
`ifdef VGA_CROSS_TILE_EN
   localparam int VBAR_W  = TILE_W / 5;
   localparam int VBAR_LO = (TILE_W - VBAR_W) / 2;
   localparam int HBAR_W  = TILE_H / 5;
   localparam int HBAR_LO = (TILE_H - HBAR_W) / 2;
   logic glyph;
`endif

   always_comb begin
      cellIdx = 8'(s1Row) * 8'(GRID_COLS) + 8'(s1Col);
      code    = '0;
      for (int k = 0; k < CELLS; k++) begin
         if (cellIdx == 8'(k)) code = codesS[4*k +: 4];
      end
      onEdge = (s1TileX < XW'(CURSOR_W)) || (s1TileX >= XW'(TILE_W - CURSOR_W)) ||
               (s1TileY < YW'(CURSOR_W)) || (s1TileY >= YW'(TILE_H - CURSOR_W));
      cursorHere = cursorEnS && (!blinkEnS || frameCnt[BLINK_SHIFT]) &&
                   (8'(cursorS) < 8'(CELLS)) && (8'(cursorS) == cellIdx);
      tileRgb = palette(code);
`ifdef VGA_CROSS_TILE_EN
      glyph = ((s1TileX >= XW'(VBAR_LO)) && (s1TileX < XW'(VBAR_LO + VBAR_W))) ||
              ((s1TileY >= YW'(HBAR_LO)) && (s1TileY < YW'(HBAR_LO + HBAR_W)));
      if (!glyph) tileRgb = 24'hFFFFFF;
`endif
      if (!s1De)                    pixRgb = 24'h000000;
      else if (!s1Grid)             pixRgb = 24'hFFFFFF;
      else if (s1Line)              pixRgb = 24'h000000;
      else if (cursorHere && onEdge) pixRgb = ~tileRgb;
      else                          pixRgb = tileRgb;
   end

   always_ff @(posedge VGA_CLK_IN or negedge rst) begin
      if (!rst) begin
         o_hsync    <= 1'b1;
         o_vsync    <= 1'b1;
         o_de       <= 1'b0;
         frame_tick <= 1'b0;
         out_R      <= '0;
         out_G      <= '0;
         out_B      <= '0;
      end else begin
         o_hsync    <= s1Hs;
         o_vsync    <= s1Vs;
         o_de       <= s1De;
         frame_tick <= s1Tick;
         {out_R, out_G, out_B} <= pixRgb;
      end
   end

endmodule

// File: tb/tb_vga_tile_grid.sv
// ---------------------------------------------------------------------------
// Directed bench for vga_tile_grid. It uses a scaled raster so that several
// frames fit in a short run:
//   H: 64 visible + 4 front + 8 sync + 4 back = 80 per line
//   V: 48 visible + 2 front + 2 sync + 3 back = 55 lines, 4400 cycles per frame
//   Grid: 3 cols x 2 rows, tile 10x8, line 2, origin (8,6), cursor 2, blink bit 1
// After posedge number E (counted from reset release), the outputs show the
// raster position E-2.
// ---------------------------------------------------------------------------
module tb_vga_tile_grid;

   logic        vgaClk = 1'b0;
   logic        rst = 1'b0;
   logic [23:0] cellCodes = '0;
   logic [2:0]  cursorIdx = '0;
   logic        cursorEn = 1'b0;
   logic        blinkEn = 1'b0;
   logic        hsync, vsync, de, frameTick, clkOut;
   logic [7:0]  outR, outG, outB;
   logic [23:0] rgb;

   int edges = 0;
   int total = 0;
   int passCnt = 0;

   always #5 vgaClk = ~vgaClk;
   assign rgb = {outR, outG, outB};

   always @(posedge vgaClk or negedge rst) begin
      if (!rst) edges <= 0;
      else      edges <= edges + 1;
   end

   vga_tile_grid #(
      .H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
      .V_VISIBLE(48), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
      .GRID_COLS(3), .GRID_ROWS(2), .TILE_W(10), .TILE_H(8), .LINE_W(2),
      .ORIGIN_X(8), .ORIGIN_Y(6), .CURSOR_W(2), .BLINK_SHIFT(1)
   ) dut (
      .VGA_CLK_IN (vgaClk),
      .rst        (rst),
      .cell_codes (cellCodes),
      .cursor_idx (cursorIdx),
      .cursor_en  (cursorEn),
      .blink_en   (blinkEn),
      .o_hsync    (hsync),
      .o_vsync    (vsync),
      .o_de       (de),
      .frame_tick (frameTick),
      .VGA_CLK_OUT(clkOut),
      .out_R      (outR),
      .out_G      (outG),
      .out_B      (outB)
   );

   task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      total++;
      assert (obs === exp) passCnt++;
      else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
   endtask

   // Advance to the negedge that follows posedge number e.
   task automatic runTo(input int e);
      int guard;
      guard = 0;
      while (edges < e && guard < 100000) begin
         @(negedge vgaClk);
         guard++;
      end
      if (edges != e) begin
         total++;
         $display("FAIL runTo: reached edge %0d, wanted %0d", edges, e);
      end
   endtask

   // Frame f, pixel (x,y) -> posedge after which it is on the outputs
   function automatic int px(input int f, input int x, input int y);
      return f * 4400 + y * 80 + x + 2;
   endfunction

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (10) @(negedge vgaClk);
      check("rst_rgb",   rgb, 24'h0);
      check("rst_hsync", 24'(hsync), 24'd1);
      check("rst_vsync", 24'(vsync), 24'd1);
      check("rst_de",    24'(de), 24'd0);
      check("rst_tick",  24'(frameTick), 24'd0);

      cellCodes = 24'h00C804;          // cell0=4, cell2=8, cell3=12
      rst = 1'b1;

      runTo(65);  check("de_last_px",  24'(de), 24'd1);
      runTo(66);  check("de_hblank",   24'(de), 24'd0);
      runTo(69);  check("hs_before",   24'(hsync), 24'd1);
      runTo(70);  check("hs_first",    24'(hsync), 24'd0);
      runTo(77);  check("hs_last",     24'(hsync), 24'd0);
      runTo(78);  check("hs_after",    24'(hsync), 24'd1);
      runTo(150); check("hs_period",   24'(hsync), 24'd0);

      // Before the first frame tick the shadow codes are still zero.
      runTo(px(0, 12, 10)); check("f0_tile_white", rgb, 24'hFFFFFF);
      runTo(px(0, 20, 10)); check("f0_line",       rgb, 24'h000000);
      runTo(px(0, 50, 10)); check("f0_outside",    rgb, 24'hFFFFFF);
      runTo(px(0, 70, 10)); check("f0_blank_rgb",  rgb, 24'h000000);
      runTo(px(0, 0, 47));  check("de_line47",     24'(de), 24'd1);
      runTo(px(0, 0, 48));  check("de_line48",     24'(de), 24'd0);

      runTo(4001); check("vs_before", 24'(vsync), 24'd1);
      runTo(4002); check("vs_first",  24'(vsync), 24'd0);
                   check("tick_on",   24'(frameTick), 24'd1);
      runTo(4003); check("tick_off",  24'(frameTick), 24'd0);
      runTo(4161); check("vs_last",   24'(vsync), 24'd0);
      runTo(4162); check("vs_after",  24'(vsync), 24'd1);

      runTo(px(1, 9, 8));   check("f1_edge_line",  rgb, 24'h000000);
      runTo(px(1, 10, 8));  check("f1_first_int",  rgb, 24'hD10E49);
      runTo(px(1, 12, 10)); check("f1_cell0",      rgb, 24'hD10E49);
      runTo(px(1, 36, 10)); check("f1_cell2",      rgb, 24'h7F8C8D);

      runTo(px(1, 0, 12) - 2);
      cellCodes = 24'h00C805;          // cell0 -> 5 mid-frame
      runTo(px(1, 12, 14)); check("f1_no_tear",    rgb, 24'hD10E49);
      runTo(px(1, 19, 15)); check("f1_last_int",   rgb, 24'hD10E49);
      runTo(px(1, 20, 15)); check("f1_line_after", rgb, 24'h000000);
      runTo(px(1, 15, 20)); check("f1_cell3",      rgb, 24'h404040);

      runTo(7000);
      cellCodes = 24'h06C805;          // cell4=6
      cursorIdx = 3'd4;
      cursorEn  = 1'b1;
      blinkEn   = 1'b0;
      runTo(8402); check("tick2", 24'(frameTick), 24'd1);

      runTo(px(2, 12, 10)); check("f2_cell0_new",  rgb, 24'h0000FF);
      runTo(px(2, 23, 19)); check("f2_cur_corner", rgb, 24'h2E3AF1);
      runTo(px(2, 15, 20)); check("f2_cell3",      rgb, 24'h404040);
      runTo(px(2, 26, 21)); check("f2_cur_inside", rgb, 24'hD1C50E);
      runTo(px(2, 29, 21)); check("f2_cur_in_r",   rgb, 24'hD1C50E);
      runTo(px(2, 30, 21)); check("f2_cur_edge_r", rgb, 24'h2E3AF1);

      runTo(11000);
      blinkEn = 1'b1;
      runTo(px(3, 23, 19)); check("blink_f3_on",  rgb, 24'h2E3AF1);
      runTo(px(4, 23, 19)); check("blink_f4_off", rgb, 24'hD1C50E);
      runTo(px(5, 23, 19)); check("blink_f5_off", rgb, 24'hD1C50E);
      runTo(px(6, 23, 19)); check("blink_f6_on",  rgb, 24'h2E3AF1);

      runTo(28000);
      blinkEn   = 1'b0;
      cursorIdx = 3'd6;                // one past the last cell
      runTo(px(7, 23, 19)); check("cursor_oob", rgb, 24'hD1C50E);

      // Assert reset in the middle of an hsync pulse.
      runTo(px(7, 70, 20)); check("pre_rst_hs", 24'(hsync), 24'd0);
      rst = 1'b0;
      #1;
      check("arst_hsync", 24'(hsync), 24'd1);
      check("arst_vsync", 24'(vsync), 24'd1);
      check("arst_de",    24'(de), 24'd0);
      check("arst_rgb",   rgb, 24'h0);
      check("arst_tick",  24'(frameTick), 24'd0);
      repeat (5) @(negedge vgaClk);
      rst = 1'b1;

      runTo(69);  check("r2_hs_before", 24'(hsync), 24'd1);
      runTo(70);  check("r2_hs_first",  24'(hsync), 24'd0);
      runTo(77);  check("r2_hs_last",   24'(hsync), 24'd0);
      runTo(78);  check("r2_hs_after",  24'(hsync), 24'd1);
      runTo(px(0, 12, 10)); check("r2_shadow_clr", rgb, 24'hFFFFFF);

      $display("%0d/%0d checks passed", passCnt, total);
      $finish;
   end

endmodule

// File: doc/vga_tile_grid.md
Name: vga_tile_grid

Overview:
- Parametrised successor to the fixed 4x4 board renderer.
- Generates 640x480@60 VGA timing and draws a GRID_COLS x GRID_ROWS board of tiles separated by black lines.
- Each tile is filled from a 4-bit per-cell colour code through a fixed 16-entry palette, with an optional blinking cursor frame.
- Sits between the game-state logic (cell codes, cursor) and the VGA DAC pins.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, h front porch
- H_SYNC, 96, h sync width
- H_BACK, 48, h back porch
- V_VISIBLE, 480, active lines
- V_FRONT, 10, v front porch
- V_SYNC, 2, v sync width
- V_BACK, 33, v back porch
- GRID_COLS, 4, tile columns (1..8)
- GRID_ROWS, 4, tile rows (1..8)
- TILE_W, 70, tile interior width in px
- TILE_H, 70, tile interior height in px
- LINE_W, 5, grid line thickness in px
- ORIGIN_X, 160, x of grid top-left outer line
- ORIGIN_Y, 120, y of grid top-left outer line
- CURSOR_W, 4, cursor frame thickness inside tile
- BLINK_SHIFT, 5, frame-counter bit driving blink

Ports:
- VGA_CLK_IN  in  1  pixel clock (25.175 MHz)
- rst  in  1  asynchronous, active-low reset
- cell_codes  in  4*GRID_COLS*GRID_ROWS  cell k at bits [4k+3:4k], k = row*GRID_COLS+col
- cursor_idx  in  $clog2(GRID_COLS*GRID_ROWS)  cursor cell index
- cursor_en  in  1  cursor frame enable
- blink_en  in  1  cursor blinks when 1
- o_hsync  out  1  h sync, active-low
- o_vsync  out  1  v sync, active-low
- o_de  out  1  display enable
- frame_tick  out  1  1-cycle pulse, first cycle of vsync
- VGA_CLK_OUT  out  1  equals VGA_CLK_IN
- out_R, out_G, out_B  out  8 each  pixel colour

Behaviour:
- Counters:
  - h_cnt runs 0..H_TOTAL-1 (800); v_cnt runs 0..V_TOTAL-1 (525).
  - v_cnt advances when h_cnt wraps.
  - Pixel (x,y) = (h_cnt,v_cnt) is visible when h_cnt<H_VISIBLE and v_cnt<V_VISIBLE.
- Sync:
  - hsync asserted (low) for h_cnt in [H_VISIBLE+H_FRONT, +H_SYNC).
  - vsync asserted likewise on v_cnt.
- Pipeline:
  - Stage 1 registers tile col/row, in-tile offsets, line/inside flags, delayed syncs and de.
  - Stage 2 registers the palette lookup and cursor overlay.
  - All outputs are registered with latency exactly 2 cycles from counter value; syncs and de are delayed identically.
- Geometry (no dividers):
  - Horizontal: an offset counter starts at x==ORIGIN_X with period TILE_W+LINE_W. Offset<LINE_W is a line; otherwise tile interior, and col increments on each period wrap.
  - Vertical: same scheme on y with TILE_H. Updated once per line, at h_cnt==H_TOTAL-1.
  - Grid extent = N*tile + (N+1)*LINE_W per axis.
  - Outside the grid the colour is white; grid lines are black.
- Palette:
  - 0 FFFFFF (hidden)
  - 1 CCFF99
  - 2 0D1E86
  - 3 00FF00
  - 4 D10E49
  - 5 0000FF
  - 6 D1C50E
  - 7 F39C12
  - 8 7F8C8D
  - 9..15 404040
- Cell-code sampling:
  - cell_codes is sampled into a shadow register on the frame_tick cycle only.
  - A mid-frame change is not visible until the next frame (no tearing).
- Cursor overlay:
  - The frame covers tile pixels within CURSOR_W of the tile interior edge in cell cursor_idx.
  - Frame colour is the bitwise inverse of the tile colour.
  - Shown when cursor_en && (!blink_en || frame_cnt[BLINK_SHIFT]).
  - cursor_idx >= cell count: no cursor drawn.
  - cursor_idx, cursor_en and blink_en are sampled with the shadow register.
- frame_cnt:
  - 8-bit, increments on frame_tick, wraps 255->0.
- Blanking:
  - When de==0, RGB is forced to 0.
- Reset (rst low, asynchronous):
  - Counters, frame_cnt, pipeline and shadow registers clear to 0.
  - o_hsync=1, o_vsync=1, o_de=0, frame_tick=0, RGB=0.
  - Release resumes from h=v=0; reset mid-line truncates the line with no glitch pulses.

Optional Feature:
- VGA_CROSS_TILE_EN
- Defined: each tile shows a plus-shaped glyph. The vertical bar is centre TILE_W/5 px wide over full height; the horizontal bar is centre TILE_H/5 px high over full width. Glyph uses the palette colour; the rest of the tile is white. The cursor still applies.
- Undefined: full-tile solid fill.

Test Plan:
- Reset held 10 cycles, released -> RGB=0, hsync=vsync=1, de=0; first hsync low at cycle 656+2; period 800 cycles.
- Free-run 2 frames -> vsync low for 1600 cycles starting at line 490; frame_tick every 420000 cycles; de high 640 cycles/line on 480 lines.
- cell_codes cell0=4, all others 0; sample (200,150) -> D10E49 two cycles later; (237,150) -> 000000 (line); (100,100) -> FFFFFF.
- Change cell0 from 4 to 5 mid-frame at line 200 -> rest of frame stays D10E49; next frame shows 0000FF.
- cursor_idx=5, cursor_en=1, blink_en=0, cell5=6 -> pixel (241,201) = 2E3AF1 (inverse); (275,235) = D1C50E. With blink_en=1, the frame toggles every 32 frames.
- Reset asserted at h=300, v=250 -> outputs reach reset values asynchronously; after release, sync timing restarts from 0 with no hsync shorter than 96 cycles.
